// File: rtl/if_fetch_if.sv
// Byte-wide unified memory read port between the fetch stage and memory.
interface if_fetch_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_rd;
  logic [7:0]            mem_din;

  modport master (output mem_a, output mem_rd, input mem_din);
  modport slave  (input mem_a, input mem_rd, output mem_din);
endinterface

// File: rtl/if_fetch.sv
// RV32I instruction fetch: owns the PC and assembles each instruction from
// four byte reads, presenting {pc, inst} to IF/ID under ctrl stall and EX redirect.
module if_fetch #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic [5:0]            stall,
  input  logic                  branch_flag_in,
  input  logic [ADDR_WIDTH-1:0] branch_target_in,
  if_fetch_if.master            mem,
  output logic [ADDR_WIDTH-1:0] if_pc_o,
  output logic [31:0]           if_inst_o,
  output logic                  if_valid_o,
  output logic                  stallreq_from_if
);

  typedef enum logic {
    FETCH,
    VALID
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [2:0]            cnt;
  logic [2:0][7:0]       byte_buf;
  logic                  stall_hi_unused;

  assign stall_hi_unused = |stall[5:2];

  // cnt sits at 4 while VALID, so mem_a already points at the next sequential word
  assign mem.mem_a        = pc + ADDR_WIDTH'(cnt);
  assign mem.mem_rd       = rdy_in & ~rst_in & (state == FETCH) & (cnt != 3'd4);
  assign stallreq_from_if = ~rst_in & (state == FETCH);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc         <= RESET_PC;
      state      <= FETCH;
      cnt        <= '0;
      byte_buf   <= '0;
      if_pc_o    <= '0;
      if_inst_o  <= '0;
      if_valid_o <= 1'b0;
    end else if (rdy_in) begin
      if (branch_flag_in) begin
        pc         <= branch_target_in;
        state      <= FETCH;
        cnt        <= '0;
        if_valid_o <= 1'b0;
      end else begin
        case (state)
          FETCH: begin
            if (cnt == 3'd4) begin
              state      <= VALID;
              if_inst_o  <= {mem.mem_din, byte_buf[2], byte_buf[1], byte_buf[0]};
              if_pc_o    <= pc;
              if_valid_o <= 1'b1;
            end else begin
              if (cnt != 3'd0) begin
                byte_buf[2'(cnt - 3'd1)] <= mem.mem_din;
              end
              cnt <= cnt + 3'd1;
            end
          end
          VALID: begin
            if (!stall[0] && !stall[1]) begin
              pc         <= pc + ADDR_WIDTH'(4);
              state      <= FETCH;
              cnt        <= '0;
              if_valid_o <= 1'b0;
            end
          end
          default: state <= FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: per-cycle vector table plus directed branch, wrap and
// reset sequences; completed instructions are checked against a scoreboard.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [5:0]  stall;
  logic        bflag;
  logic [31:0] btgt;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        sreq;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  if_fetch_if #(.ADDR_WIDTH(32)) bus ();

  if_fetch #(.ADDR_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .rdy_in          (rdy),
    .stall           (stall),
    .branch_flag_in  (bflag),
    .branch_target_in(btgt),
    .mem             (bus.master),
    .if_pc_o         (if_pc),
    .if_inst_o       (if_inst),
    .if_valid_o      (if_valid),
    .stallreq_from_if(sreq)
  );

  // Read-enabled byte memory, one cycle of latency
  logic [7:0] mem [1024];
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_din <= mem[bus.mem_a[9:0]];
  end

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] a1, a2, a3;
    a1 = a + 32'd1;
    a2 = a + 32'd2;
    a3 = a + 32'd3;
    return {mem[a3[9:0]], mem[a2[9:0]], mem[a1[9:0]], mem[a[9:0]]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   seen = 0;

  always @(negedge clk) begin
    if (rst) begin
      seen = 0;
    end else if (if_valid === 1'b1) begin
      if (!seen) begin
        seen = 1;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: actual pc %0h required no instruction", if_pc);
        end else begin
          cur = sb.pop_front();
          check("sb_pc", {32'h0, if_pc}, {32'h0, cur.pc});
          check("sb_inst", {32'h0, if_inst}, {32'h0, cur.inst});
        end
      end else begin
        check("hold_pc", {32'h0, if_pc}, {32'h0, cur.pc});
        check("hold_inst", {32'h0, if_inst}, {32'h0, cur.inst});
      end
    end else begin
      seen = 0;
    end
  end

  typedef struct {
    logic        rdy;
    logic [5:0]  stall;
    logic        chk_a;
    logic [31:0] a;
    logic        rd;
    logic        valid;
    logic        sreq;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [5:0] s, input logic ca,
                              input logic [31:0] a, input logic rd, input logic v,
                              input logic sr);
    vec_t t;
    t.rdy = r; t.stall = s; t.chk_a = ca; t.a = a; t.rd = rd; t.valid = v; t.sreq = sr;
    return t;
  endfunction

  task automatic wait_valid(input string name, input int unsigned limit);
    for (int unsigned k = 0; k < limit; k++) begin
      @(negedge clk);
      if (if_valid === 1'b1) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s: actual timeout after %0d cycles required if_valid_o", name, limit);
  endtask

  task automatic chk_fetch(input string name, input logic [31:0] a);
    check({name, "_mem_a"}, {32'h0, bus.mem_a}, {32'h0, a});
    check({name, "_mem_rd"}, {63'h0, bus.mem_rd}, 64'h1);
  endtask

  vec_t tbl[$];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 37 + 11);
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;

    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 6'h00, 1, 32'(i), 1, 0, 1));
    tbl.push_back(mk(1, 6'h00, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 6'h00, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 6'h00, 1, 4, 1, 0, 1));
    tbl.push_back(mk(1, 6'h00, 1, 5, 1, 0, 1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 6'h00, 1, 6, 0, 0, 1));
    tbl.push_back(mk(1, 6'h00, 1, 6, 1, 0, 1));
    tbl.push_back(mk(1, 6'h00, 1, 7, 1, 0, 1));
    tbl.push_back(mk(1, 6'h00, 0, 0, 0, 0, 1));
    for (int i = 0; i < 10; i++) tbl.push_back(mk(1, 6'b000111, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 6'h00, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 6'h00, 1, 8, 1, 0, 1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 6'b000111, 1, 32'(9 + i), 1, 0, 1));
    tbl.push_back(mk(1, 6'b000111, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 6'b000010, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 6'b000001, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 6'b111100, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 6'h00, 1, 12, 1, 0, 1));

    rst = 1'b1; rdy = 1'b1; stall = '0; bflag = 1'b0; btgt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {63'h0, if_valid}, 64'h0);
    check("rst_pc", {32'h0, if_pc}, 64'h0);
    check("rst_inst", {32'h0, if_inst}, 64'h0);
    check("rst_sreq", {63'h0, sreq}, 64'h0);
    check("rst_mem_rd", {63'h0, bus.mem_rd}, 64'h0);

    sb.push_back('{pc: 32'h0, inst: 32'h00100513});
    sb.push_back('{pc: 32'h4, inst: word_at(32'h4)});
    sb.push_back('{pc: 32'h8, inst: word_at(32'h8)});

    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      rdy   = tbl[i].rdy;
      stall = tbl[i].stall;
      @(negedge clk);
      if (tbl[i].chk_a)
        check($sformatf("row%0d_mem_a", i), {32'h0, bus.mem_a}, {32'h0, tbl[i].a});
      check($sformatf("row%0d_mem_rd", i), {63'h0, bus.mem_rd}, {63'h0, tbl[i].rd});
      check($sformatf("row%0d_valid", i), {63'h0, if_valid}, {63'h0, tbl[i].valid});
      check($sformatf("row%0d_sreq", i), {63'h0, sreq}, {63'h0, tbl[i].sreq});
      @(posedge clk); #1;
    end
    rdy = 1'b1; stall = '0;

    // redirect at cnt = 2 of the fetch for pc 12
    @(posedge clk); #1;
    bflag = 1'b1; btgt = 32'h100;
    @(negedge clk);
    check("br_cnt2_mem_a", {32'h0, bus.mem_a}, 64'd14);
    sb.push_back('{pc: 32'h100, inst: word_at(32'h100)});
    @(posedge clk); #1;
    bflag = 1'b0;
    @(negedge clk);
    chk_fetch("br_first", 32'h100);
    check("br_valid", {63'h0, if_valid}, 64'h0);
    wait_valid("br_wait", 20);
    check("br_pc", {32'h0, if_pc}, 64'h100);

    // redirect beats stall[1] while VALID, target near the top of memory
    bflag = 1'b1; btgt = 32'hFFFF_FFFE; stall = 6'b000010;
    sb.push_back('{pc: 32'hFFFF_FFFE, inst: word_at(32'hFFFF_FFFE)});
    @(posedge clk); #1;
    bflag = 1'b0; stall = '0;
    @(negedge clk);
    check("brst_valid", {63'h0, if_valid}, 64'h0);
    chk_fetch("wrap0", 32'hFFFF_FFFE);
    @(posedge clk); #1; @(negedge clk); chk_fetch("wrap1", 32'hFFFF_FFFF);
    @(posedge clk); #1; @(negedge clk); chk_fetch("wrap2", 32'h0);
    @(posedge clk); #1; @(negedge clk); chk_fetch("wrap3", 32'h1);
    wait_valid("wrap_wait", 20);
    sb.push_back('{pc: 32'h2, inst: word_at(32'h2)});
    @(posedge clk); #1;
    @(negedge clk);
    chk_fetch("wrap_next", 32'h2);

    // reset in the middle of the fetch for pc 2
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("mrst_valid", {63'h0, if_valid}, 64'h0);
    check("mrst_mem_a", {32'h0, bus.mem_a}, 64'h0);
    check("mrst_sreq", {63'h0, sreq}, 64'h0);
    sb.delete();
    sb.push_back('{pc: 32'h0, inst: 32'h00100513});
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_fetch("mrst_first", 32'h0);
    wait_valid("mrst_wait", 20);
    @(posedge clk); #1;
    check("sb_drained", 64'(sb.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
